// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Demand-driven phase controller for a two-street intersection. Replaces a
// fixed green/yellow/red counter with configurable phase durations. Side-street
// demand is latched. The controller rests on green while nobody on the other
// street is waiting. Every green-to-green change passes through yellow and an
// all-red clearance. An emergency request can pull the green toward a chosen
// street.
//
// Parameters
//   TICK_DIV  clk cycles per timing tick (1 allowed for fast simulation)
//   MIN_G     minimum green duration in ticks (1..255)
//   Y_TIME    yellow duration in ticks (1..255)
//   AR_TIME   all-red clearance duration in ticks (1..255)
//
// Ports
//   clk         system clock, everything on the rising edge
//   rst         synchronous active-high reset
//   req_a       demand for street A green (pulse or held)
//   req_b       demand for street B green (pulse or held)
//   emg         emergency preemption request, level-sensitive
//   emg_dir     preemption target: 0 = street A, 1 = street B
//   street_a    light code {red,yellow,green} for street A
//   street_b    light code {red,yellow,green} for street B
//   phase       current state encoding (AG=0 AY=1 AR1=2 BG=3 BY=4 AR2=5)
//   dem_a       latched demand for street A
//   dem_b       latched demand for street B
//   emg_active  high while the current green is held by preemption
// ---------------------------------------------------------------------------
module traffic_phase_scheduler #(
    parameter int TICK_DIV = 1000,
    parameter int MIN_G    = 10,
    parameter int Y_TIME   = 3,
    parameter int AR_TIME  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       emg,
    input  logic       emg_dir,
    output logic [2:0] street_a,
    output logic [2:0] street_b,
    output logic [2:0] phase,
    output logic       dem_a,
    output logic       dem_b,
    output logic       emg_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    MIN_G_T    = 8'(MIN_G);
    localparam logic [7:0]    Y_LAST     = 8'(Y_TIME - 1);
    localparam logic [7:0]    AR_LAST    = 8'(AR_TIME - 1);

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        AG  = 3'd0,
        AY  = 3'd1,
        AR1 = 3'd2,
        BG  = 3'd3,
        BY  = 3'd4,
        AR2 = 3'd5
    } phaseT;

    phaseT           phaseState_q, phaseState_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      timer_q, timer_d;
    logic            demA_q, demA_d;
    logic            demB_q, demB_d;

    logic            tick;
    logic            yExpire;
    logic            arExpire;
    logic            stateChange;

    // A tick fires on the last prescaler count. An interval of D ticks
    // expires on the tick seen while the elapsed count is still D-1.
    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        yExpire  = tick && (timer_q == Y_LAST);
        arExpire = tick && (timer_q == AR_LAST);
    end

    // Next-state logic. Yellow and all-red always run their full length,
    // even under preemption. Greens either jump straight to yellow for an
    // opposing emergency, hold for a same-street emergency, or leave once
    // the minimum green has elapsed and the other street has latched demand.
    // The green checks run on every cycle, not only on tick cycles.
    always_comb begin
        phaseState_d = phaseState_q;
        case (phaseState_q)
            AG: begin
                if (emg) begin
                    if (emg_dir) begin
                        phaseState_d = AY;
                    end
                end else if ((timer_q >= MIN_G_T) && demB_q) begin
                    phaseState_d = AY;
                end
            end
            AY: begin
                if (yExpire) begin
                    phaseState_d = AR1;
                end
            end
            AR1: begin
                if (arExpire) begin
                    phaseState_d = (emg && !emg_dir) ? AG : BG;
                end
            end
            BG: begin
                if (emg) begin
                    if (!emg_dir) begin
                        phaseState_d = BY;
                    end
                end else if ((timer_q >= MIN_G_T) && demA_q) begin
                    phaseState_d = BY;
                end
            end
            BY: begin
                if (yExpire) begin
                    phaseState_d = AR2;
                end
            end
            AR2: begin
                if (arExpire) begin
                    phaseState_d = (emg && emg_dir) ? BG : AG;
                end
            end
            default: begin
                phaseState_d = AR2;
            end
        endcase
    end

    // Phase timing. The prescaler and the elapsed-tick timer restart on
    // every state change, so each phase of N ticks lasts exactly
    // N*TICK_DIV cycles. The timer saturates so that an indefinite rest
    // on green cannot wrap back below the minimum green.
    always_comb begin
        stateChange = (phaseState_d != phaseState_q);
        presc_d     = presc_q;
        timer_d     = timer_q;
        if (stateChange) begin
            presc_d = '0;
            timer_d = 8'd0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick && (timer_q != 8'hFF)) begin
                timer_d = timer_q + 8'd1;
            end
        end
    end

    // Demand latches. Entering a street's green clears its demand, and the
    // clear takes priority over a request on the same edge. A request made
    // while that street already has the green is not latched.
    always_comb begin
        demA_d = demA_q;
        demB_d = demB_q;
        if ((phaseState_d == AG) && (phaseState_q != AG)) begin
            demA_d = 1'b0;
        end else if (req_a && (phaseState_q != AG)) begin
            demA_d = 1'b1;
        end
        if ((phaseState_d == BG) && (phaseState_q != BG)) begin
            demB_d = 1'b0;
        end else if (req_b && (phaseState_q != BG)) begin
            demB_d = 1'b1;
        end
    end

    // State registers. Reset lands in the second all-red so that the first
    // green after reset goes to street A after one clearance interval. A
    // reset in mid-yellow abandons that yellow.
    always_ff @(posedge clk) begin
        if (rst) begin
            phaseState_q <= AR2;
            presc_q      <= '0;
            timer_q      <= 8'd0;
            demA_q       <= 1'b0;
            demB_q       <= 1'b0;
        end else begin
            phaseState_q <= phaseState_d;
            presc_q      <= presc_d;
            timer_q      <= timer_d;
            demA_q       <= demA_d;
            demB_q       <= demB_d;
        end
    end

    // Light outputs are decoded from the state register alone, so the two
    // streets can never both be non-red. The preemption flag also looks at
    // the live emergency inputs, because a held green depends on them.
    always_comb begin
        street_a   = LIGHT_RED;
        street_b   = LIGHT_RED;
        case (phaseState_q)
            AG:      street_a = LIGHT_GREEN;
            AY:      street_a = LIGHT_YELLOW;
            BG:      street_b = LIGHT_GREEN;
            BY:      street_b = LIGHT_YELLOW;
            default: begin
                street_a = LIGHT_RED;
                street_b = LIGHT_RED;
            end
        endcase
        phase      = phaseState_q;
        dem_a      = demA_q;
        dem_b      = demB_q;
        emg_active = ((phaseState_q == AG) && emg && !emg_dir)
                  || ((phaseState_q == BG) && emg && emg_dir);
    end

endmodule
